// File: rtl/vending_pkg.sv
// Shared constants and helpers for the vending controller: coin code ranges and values,
// change-coin and FSM encodings, error codes and the 7-segment digit table.
package vending_pkg;

    localparam int unsigned CreditW = 7;

    localparam int unsigned PennyLo   = 745;
    localparam int unsigned PennyHi   = 754;
    localparam int unsigned NickelLo  = 830;
    localparam int unsigned NickelHi  = 839;
    localparam int unsigned DimeLo    = 700;
    localparam int unsigned DimeHi    = 709;
    localparam int unsigned QuarterLo = 950;
    localparam int unsigned QuarterHi = 959;

    localparam logic [CreditW-1:0] ValPenny   = 7'd1;
    localparam logic [CreditW-1:0] ValNickel  = 7'd5;
    localparam logic [CreditW-1:0] ValDime    = 7'd10;
    localparam logic [CreditW-1:0] ValQuarter = 7'd25;

    typedef enum logic [1:0] {
        CoinPenny   = 2'd0,
        CoinNickel  = 2'd1,
        CoinDime    = 2'd2,
        CoinQuarter = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StVend,
        StChange,
        StError
    } state_e;

    typedef enum logic [1:0] {
        ErrNone  = 2'd0,
        ErrFunds = 2'd1,
        ErrEmpty = 2'd2
    } err_e;

    localparam logic [6:0] SegE = 7'h79;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Largest coin not exceeding the remaining credit.
    function automatic coin_e greedy_coin(input logic [CreditW-1:0] c);
        if (c >= ValQuarter)     return CoinQuarter;
        else if (c >= ValDime)   return CoinDime;
        else if (c >= ValNickel) return CoinNickel;
        else                     return CoinPenny;
    endfunction

    function automatic logic [CreditW-1:0] coin_val(input coin_e c);
        case (c)
            CoinQuarter: return ValQuarter;
            CoinDime:    return ValDime;
            CoinNickel:  return ValNickel;
            default:     return ValPenny;
        endcase
    endfunction

endpackage

// File: rtl/vending_machine_gen_if.sv
// Front-panel and coin-acceptor signals of the vending controller.
// master drives requests and coin bits; slave is the controller.
interface vending_machine_gen_if #(
    parameter int unsigned PROD_W = 2
) ();

    logic              serialIn;
    logic              enable;
    logic [PROD_W-1:0] product;
    logic              buy;
    logic              restock;
    logic [6:0]        digit1;
    logic [6:0]        digit0;
    logic              vend;
    logic [PROD_W-1:0] vend_product;
    logic              coin_reject;
    logic              change_valid;
    logic [1:0]        change_coin;

    modport master (
        output serialIn, enable, product, buy, restock,
        input  digit1, digit0, vend, vend_product, coin_reject, change_valid, change_coin
    );

    modport slave (
        input  serialIn, enable, product, buy, restock,
        output digit1, digit0, vend, vend_product, coin_reject, change_valid, change_coin
    );

endinterface

// File: rtl/coin_rx.sv
// Serial coin-code receiver: shifts MSB-first frames while enable is high and classifies
// each completed frame by code range into a coin value or an invalid-coin pulse.
module coin_rx
    import vending_pkg::*;
#(
    parameter int unsigned CODE_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               serial_in,
    input  logic               enable,
    output logic               coin_valid,
    output logic               coin_invalid,
    output logic [CreditW-1:0] coin_value
);

    localparam int unsigned CntW = $clog2(CODE_W);

    logic [CODE_W-2:0]  shift_q;
    logic [CntW-1:0]    cnt_q;
    logic [CODE_W-1:0]  code;
    logic               code_ok;
    logic [CreditW-1:0] code_val;

    assign code = {shift_q, serial_in};

    function automatic logic in_range(input logic [CODE_W-1:0] c, input int unsigned lo,
                                      input int unsigned hi);
        return (c >= CODE_W'(lo)) && (c <= CODE_W'(hi));
    endfunction

    always_comb begin
        code_ok  = 1'b1;
        code_val = '0;
        if (in_range(code, PennyLo, PennyHi))          code_val = ValPenny;
        else if (in_range(code, NickelLo, NickelHi))   code_val = ValNickel;
        else if (in_range(code, DimeLo, DimeHi))       code_val = ValDime;
        else if (in_range(code, QuarterLo, QuarterHi)) code_val = ValQuarter;
        else                                           code_ok  = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            coin_valid   <= 1'b0;
            coin_invalid <= 1'b0;
            coin_value   <= '0;
        end else begin
            coin_valid   <= 1'b0;
            coin_invalid <= 1'b0;
            if (enable) begin
                shift_q <= code[CODE_W-2:0];
                if (cnt_q == CntW'(CODE_W - 1)) begin
                    cnt_q        <= '0;
                    coin_valid   <= code_ok;
                    coin_invalid <= ~code_ok;
                    coin_value   <= code_val;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end else begin
                // A dropped enable abandons any partial frame without a reject.
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: credits classified coins, checks stock and price on a
// buy edge, vends, pays greedy change one coin per cycle and drives two credit digits.
module vending_machine_gen
    import vending_pkg::*;
#(
    parameter int unsigned                 CODE_W       = 10,
    parameter int unsigned                 NUM_PRODUCTS = 4,
    parameter int unsigned                 PROD_W       = 2,
    parameter logic [7*NUM_PRODUCTS-1:0]   PRICES       = {7'd90, 7'd35, 7'd50, 7'd75},
    parameter int unsigned                 STOCK_W      = 4,
    parameter int unsigned                 INIT_STOCK   = 5,
    parameter int unsigned                 CREDIT_MAX   = 99,
    parameter int unsigned                 DISP_HOLD    = 8
) (
    input logic                  clk,
    input logic                  reset,
    vending_machine_gen_if.slave bus
);

    localparam int unsigned SumW  = CreditW + 1;
    localparam int unsigned HoldW = $clog2(DISP_HOLD + 1);

    logic               coin_valid;
    logic               coin_invalid;
    logic [CreditW-1:0] coin_value;

    state_e             state_q;
    logic [CreditW-1:0] credit_q;
    logic [PROD_W-1:0]  prod_q;
    err_e               err_q;
    logic [HoldW-1:0]   hold_q;
    logic               buy_q;
    logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
    logic               vend_q;
    logic [PROD_W-1:0]  vend_prod_q;
    logic               reject_q;
    logic               chg_valid_q;
    coin_e              chg_coin_q;
    logic [6:0]         digit1_q;
    logic [6:0]         digit0_q;

    logic               buy_rise;
    logic [SumW-1:0]    sum;
    logic               coin_ok;
    logic [CreditW-1:0] price;
    coin_e              chg_coin;
    logic [CreditW-1:0] chg_left;

    coin_rx #(
        .CODE_W(CODE_W)
    ) u_coin_rx (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (bus.serialIn),
        .enable      (bus.enable),
        .coin_valid  (coin_valid),
        .coin_invalid(coin_invalid),
        .coin_value  (coin_value)
    );

    assign buy_rise = bus.buy & ~buy_q;
    assign sum      = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ok  = (state_q == StIdle) && coin_valid && (sum <= SumW'(CREDIT_MAX));
    assign price    = PRICES[int'(prod_q) * CreditW +: CreditW];
    assign chg_coin = greedy_coin(credit_q);
    assign chg_left = credit_q - coin_val(chg_coin);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            prod_q      <= '0;
            err_q       <= ErrNone;
            hold_q      <= '0;
            buy_q       <= 1'b0;
            vend_q      <= 1'b0;
            vend_prod_q <= '0;
            reject_q    <= 1'b0;
            chg_valid_q <= 1'b0;
            chg_coin_q  <= CoinPenny;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            buy_q       <= bus.buy;
            vend_q      <= 1'b0;
            reject_q    <= 1'b0;
            chg_valid_q <= 1'b0;

            // Coin is credited before a same-cycle buy edge reaches CHECK.
            if (coin_ok) begin
                credit_q <= sum[CreditW-1:0];
            end else if (coin_valid || coin_invalid) begin
                reject_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (buy_rise) begin
                        prod_q  <= bus.product;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (stock_q[prod_q] == '0) begin
                        err_q   <= ErrEmpty;
                        hold_q  <= HoldW'(DISP_HOLD - 1);
                        state_q <= StError;
                    end else if (credit_q < price) begin
                        err_q   <= ErrFunds;
                        hold_q  <= HoldW'(DISP_HOLD - 1);
                        state_q <= StError;
                    end else begin
                        vend_q           <= 1'b1;
                        vend_prod_q      <= prod_q;
                        credit_q         <= credit_q - price;
                        stock_q[prod_q]  <= stock_q[prod_q] - STOCK_W'(1);
                        state_q          <= StVend;
                    end
                end
                StVend, StChange: begin
                    if (credit_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        chg_valid_q <= 1'b1;
                        chg_coin_q  <= chg_coin;
                        credit_q    <= chg_left;
                        state_q     <= (chg_left == '0) ? StIdle : StChange;
                    end
                end
                StError: begin
                    if (hold_q == '0) state_q <= StIdle;
                    else              hold_q  <= hold_q - HoldW'(1);
                end
                default: state_q <= StIdle;
            endcase

            // Placed last so a restock overrides a same-cycle vend decrement.
            if (bus.restock) stock_q[bus.product] <= STOCK_W'(INIT_STOCK);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit1_q <= seg7(4'd0);
            digit0_q <= seg7(4'd0);
        end else if (state_q == StError) begin
            digit1_q <= SegE;
            digit0_q <= seg7({2'b00, err_q});
        end else begin
            digit1_q <= seg7(4'(credit_q / 7'd10));
            digit0_q <= seg7(4'(credit_q % 7'd10));
        end
    end

    assign bus.digit1       = digit1_q;
    assign bus.digit0       = digit0_q;
    assign bus.vend         = vend_q;
    assign bus.vend_product = vend_prod_q;
    assign bus.coin_reject  = reject_q;
    assign bus.change_valid = chg_valid_q;
    assign bus.change_coin  = chg_coin_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Scoreboard bench for vending_machine_gen: stimulus pushes expected events and display
// values into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_vending_machine_gen;

    localparam int EvVend   = 1;
    localparam int EvReject = 2;
    localparam int EvChange = 3;
    localparam logic [13:0] DispE1 = {7'h79, 7'h06};
    localparam logic [13:0] DispE2 = {7'h79, 7'h5B};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vending_machine_gen_if #(.PROD_W(2)) bus ();

    vending_machine_gen #(
        .CODE_W      (10),
        .NUM_PRODUCTS(4),
        .PROD_W      (2),
        .PRICES      ({7'd90, 7'd35, 7'd50, 7'd75}),
        .STOCK_W     (4),
        .INIT_STOCK  (1),
        .CREDIT_MAX  (99),
        .DISP_HOLD   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          evq[$];
    logic [13:0] dispq[$];
    logic [13:0] last_disp = {7'h3F, 7'h3F};
    bit          mon_en    = 1'b0;
    int          mcredit   = 0;
    logic [6:0]  seg [10]  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic mon_event(input string name, input int got);
        if (evq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got 0x%0h expected no event", name, got);
        end else begin
            check(name, got, evq.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (bus.vend)         mon_event("vend", EvVend * 16 + int'(bus.vend_product));
            if (bus.coin_reject)  mon_event("coin_reject", EvReject * 16);
            if (bus.change_valid) mon_event("change", EvChange * 16 + int'(bus.change_coin));
            if ({bus.digit1, bus.digit0} != last_disp) begin
                last_disp = {bus.digit1, bus.digit0};
                if (dispq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL display: got 0x%0h expected no change", last_disp);
                end else begin
                    check("display", int'(last_disp), int'(dispq.pop_front()));
                end
            end
        end
    end

    function automatic logic [13:0] disp_of(input int c);
        return {seg[c / 10], seg[c % 10]};
    endfunction

    task automatic exp_credit(input int c);
        mcredit = c;
        dispq.push_back(disp_of(c));
    endtask

    task automatic send_bits(input logic [9:0] code, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.serialIn = code[9-i];
            bus.enable   = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_coin(input logic [9:0] code);
        send_bits(code, 10);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Expected outcome is queued before the frame is shifted in.
    task automatic coin(input logic [9:0] code, input int value);
        if (value > 0 && mcredit + value <= 99) exp_credit(mcredit + value);
        else evq.push_back(EvReject * 16);
        send_coin(code);
    endtask

    task automatic do_buy(input int p);
        bus.product = 2'(p);
        bus.buy     = 1'b1;
        @(posedge clk);
        #1;
        bus.buy = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        if (mcredit != 0) dispq.push_back(disp_of(0));
        mcredit = 0;
        #1 reset = 1'b0;
        #1;
        check("reset_digit1", int'(bus.digit1), 'h3F);
        check("reset_digit0", int'(bus.digit0), 'h3F);
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        int hold;

        reset        = 1'b0;
        bus.serialIn = 1'b0;
        bus.enable   = 1'b0;
        bus.product  = '0;
        bus.buy      = 1'b0;
        bus.restock  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit1", int'(bus.digit1), 'h3F);
        check("rst_digit0", int'(bus.digit0), 'h3F);
        check("rst_vend", int'(bus.vend), 0);
        check("rst_reject", int'(bus.coin_reject), 0);
        check("rst_change_valid", int'(bus.change_valid), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Ten pennies, then an underfunded banana.
        for (int i = 0; i < 10; i++) coin(10'd750, 1);
        wait_cycles(3);
        dispq.push_back(DispE1);
        dispq.push_back(disp_of(10));
        do_buy(1);
        hold = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ({bus.digit1, bus.digit0} == DispE1) hold++;
            else if (hold > 0) break;
        end
        check("error_hold_cycles", hold, 8);
        wait_cycles(3);

        // 85 cents, banana with quarter+dime change.
        @(posedge clk);
        pulse_reset();
        @(posedge clk);
        #1;
        coin(10'd955, 25);
        coin(10'd955, 25);
        coin(10'd955, 25);
        coin(10'd705, 10);
        wait_cycles(3);
        evq.push_back(EvVend * 16 + 1);
        evq.push_back(EvChange * 16 + 3);
        evq.push_back(EvChange * 16 + 2);
        dispq.push_back(disp_of(35));
        dispq.push_back(disp_of(10));
        dispq.push_back(disp_of(0));
        mcredit = 0;
        do_buy(1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.vend) begin
                lat = i;
                break;
            end
        end
        check("vend_latency", lat, 2);
        wait_cycles(8);

        // Credit ceiling: tenth dime bounces; then buy the date exactly.
        for (int i = 0; i < 10; i++) coin(10'd705, 10);
        wait_cycles(3);
        evq.push_back(EvVend * 16 + 3);
        dispq.push_back(disp_of(0));
        mcredit = 0;
        do_buy(3);
        wait_cycles(8);

        // Carrot twice with stock 1, then restock and buy again.
        coin(10'd955, 25);
        coin(10'd705, 10);
        wait_cycles(3);
        evq.push_back(EvVend * 16 + 2);
        dispq.push_back(disp_of(0));
        mcredit = 0;
        do_buy(2);
        wait_cycles(8);
        coin(10'd955, 25);
        coin(10'd705, 10);
        wait_cycles(3);
        dispq.push_back(DispE2);
        dispq.push_back(disp_of(35));
        do_buy(2);
        wait_cycles(14);
        bus.product = 2'd2;
        bus.restock = 1'b1;
        @(posedge clk);
        #1;
        bus.restock = 1'b0;
        evq.push_back(EvVend * 16 + 2);
        dispq.push_back(disp_of(0));
        mcredit = 0;
        do_buy(2);
        wait_cycles(8);

        // Aborted frame, then code-range boundaries.
        send_bits(10'd835, 6);
        bus.enable = 1'b0;
        wait_cycles(2);
        coin(10'd835, 5);
        coin(10'd744, 0);
        coin(10'd760, 0);
        coin(10'd754, 1);
        coin(10'd745, 1);
        coin(10'd839, 5);
        coin(10'd700, 10);
        wait_cycles(3);

        // Reset during bit 5 of a quarter frame, then a clean quarter.
        send_bits(10'd955, 4);
        bus.serialIn = 1'b0;
        bus.enable   = 1'b1;
        pulse_reset();
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        coin(10'd955, 25);

        wait_cycles(20);
        check("events_drained", evq.size(), 0);
        check("display_drained", dispq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
